tt_um_watbulb_param_fifo: RTL and testbench

TT_UM_WATBULB_PARAM_FIFO -- requirements
Module: tt_um_watbulb_param_fifo

---
 rtl/tt_um_watbulb_param_fifo.sv | 112 +++++++++++
 tb/tb_tt_um_watbulb_param_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_watbulb_param_fifo.sv
// Parameterised synchronous FIFO on the TinyTapeout 8-in/8-out pin map.
// Define WATBULB_FIFO_FWFT_EN for first-word-fall-through output; the default is a registered read port.
module tt_um_watbulb_param_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] dat_in;
    logic                  wr_en;
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  full, empty;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] dat_out;

    assign dat_in = ui_in[DATA_WIDTH-1:0];
    assign wr_en  = ui_in[6];
    assign rd_en  = ui_in[7];

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        full   = (count_q == COUNT_MAX);
        empty  = (count_q == '0);
        wr_acc = wr_en && !full;
        rd_acc = rd_en && !empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left unreset; nothing observes an unwritten entry.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= dat_in;
        end
    end

`ifdef WATBULB_FIFO_FWFT_EN
    assign dat_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dat_out = dout_q;
`endif

    always_comb begin
        uo_out                   = '0;
        uo_out[DATA_WIDTH-1:0]   = dat_out;
        uo_out[6]                = full;
        uo_out[7]                = empty;
    end

endmodule

// File: tb/tb_tt_um_watbulb_param_fifo.sv
// Self-checking bench: a default FIFO and a DEPTH=3 FIFO checked against queue models
// every cycle, plus directed literal expectations for both output modes.
module tb_tt_um_watbulb_param_fifo;

    localparam int D0 = 4;
    localparam int D1 = 3;
`ifdef WATBULB_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui0, ui1;
    logic [7:0] uo0, uo1;

    int n_checks = 0;
    int n_fail   = 0;

    tt_um_watbulb_param_fifo dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui0),
        .uo_out (uo0)
    );

    tt_um_watbulb_param_fifo #(.DATA_WIDTH(6), .DEPTH(D1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui1),
        .uo_out (uo1)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the last word popped.
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] last0 = '0;
    logic [5:0] last1 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
        end else begin
            bit wa0, ra0, wa1, ra1;
            wa0 = ui0[6] && (q0.size() < D0);
            ra0 = ui0[7] && (q0.size() > 0);
            wa1 = ui1[6] && (q1.size() < D1);
            ra1 = ui1[7] && (q1.size() > 0);
            if (ra0) last0 = q0.pop_front();
            if (wa0) q0.push_back(ui0[5:0]);
            if (ra1) last1 = q1.pop_front();
            if (wa1) q1.push_back(ui1[5:0]);
        end
    end

    function automatic logic [7:0] model_byte(input int size, input int depth,
                                              input logic [5:0] last, input logic [5:0] head);
        logic [5:0] d;
        d = FWFT ? ((size == 0) ? 6'h00 : head) : last;
        return {(size == 0), (size == depth), d};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model0", uo0, model_byte(q0.size(), D0, last0, (q0.size() > 0) ? q0[0] : 6'h00));
        checkOutput("model1", uo1, model_byte(q1.size(), D1, last1, (q1.size() > 0) ? q1[0] : 6'h00));
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        ui0 = a;
        ui1 = b;
        @(posedge clk);
        #2;
    endtask

    logic [5:0] got [10];
    int         got_n = 0;

    task automatic readOne1();
        if (FWFT) begin
            got[got_n] = uo1[5:0];
            applyStimulus(8'h00, 8'h80);
        end else begin
            applyStimulus(8'h00, 8'h80);
            got[got_n] = uo1[5:0];
        end
        got_n++;
    endtask

    initial begin
        rst_n = 1'b0;
        ui0   = 8'h00;
        ui1   = 8'h00;
        #1;
        checkOutput("reset0", uo0, 8'h80);
        checkOutput("reset1", uo1, 8'h80);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill to full, drop a fifth write, then drain and over-read.
        applyStimulus(8'h41, 8'h00);
        applyStimulus(8'h42, 8'h00);
        applyStimulus(8'h43, 8'h00);
        applyStimulus(8'h44, 8'h00);
        checkOutput("full_after4", uo0, FWFT ? 8'h41 : 8'h40);
        applyStimulus(8'h7F, 8'h00);
        checkOutput("drop_when_full", uo0, FWFT ? 8'h41 : 8'h40);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(8'h80, 8'h00);
            checkOutput("read_order", uo0,
                        FWFT ? ((i == 4) ? 8'h80 : 8'(i + 1)) : ((i == 4) ? 8'h84 : 8'(i)));
        end
        applyStimulus(8'h80, 8'h00);
        checkOutput("read_at_empty", uo0, FWFT ? 8'h80 : 8'h84);
        applyStimulus(8'h00, 8'h00);

        // Simultaneous read and write at count 2 and at full.
        applyStimulus(8'h50, 8'h00);
        applyStimulus(8'h51, 8'h00);
        applyStimulus(8'hD2, 8'h00);
        checkOutput("simul_count2", uo0, FWFT ? 8'h11 : 8'h10);
        applyStimulus(8'h53, 8'h00);
        applyStimulus(8'h54, 8'h00);
        checkOutput("refill_full", uo0, FWFT ? 8'h51 : 8'h50);
        applyStimulus(8'hD5, 8'h00);
        checkOutput("simul_full", uo0, FWFT ? 8'h12 : 8'h11);
        applyStimulus(8'h80, 8'h00);
        applyStimulus(8'h80, 8'h00);
        applyStimulus(8'h80, 8'h00);
        checkOutput("drain_simul", uo0, FWFT ? 8'h80 : 8'h94);
        applyStimulus(8'h00, 8'h00);

        // DEPTH=3 instance: ten words through wrapping pointers.
        applyStimulus(8'h00, 8'h40);
        applyStimulus(8'h00, 8'h41);
        checkOutput("d3_not_full_at2", uo1, 8'h00);
        applyStimulus(8'h00, 8'h42);
        checkOutput("d3_full_at3", uo1, 8'h40);
        for (int k = 0; k < 7; k++) begin
            readOne1();
            applyStimulus(8'h00, 8'(8'h40 + 8'(k + 3)));
        end
        readOne1();
        readOne1();
        readOne1();
        for (int i = 0; i < 10; i++) begin
            checkOutput("d3_order", {2'b00, got[i]}, 8'(i));
        end
        checkOutput("d3_drained", uo1, FWFT ? 8'h80 : 8'h89);
        applyStimulus(8'h00, 8'h00);

        // Asynchronous reset pulse between edges with three words stored.
        applyStimulus(8'h61, 8'h00);
        applyStimulus(8'h62, 8'h00);
        applyStimulus(8'h63, 8'h00);
        ui0   = 8'h00;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", uo0, 8'h80);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        ui0   = 8'h7F;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("write_in_reset", uo0, 8'h80);
        ui0   = 8'h6A;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("first_edge_after_reset", uo0, FWFT ? 8'h2A : 8'h00);
        applyStimulus(8'h80, 8'h00);
        checkOutput("read_after_reset", uo0, FWFT ? 8'h80 : 8'hAA);

        // Single word into an empty FIFO, then popped.
        applyStimulus(8'h55, 8'h00);
        checkOutput("write_into_empty", uo0, FWFT ? 8'h15 : 8'h2A);
        applyStimulus(8'h80, 8'h00);
        checkOutput("pop_single", uo0, FWFT ? 8'h80 : 8'h95);
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
